// File: rtl/mem_wb_stage_pkg.sv
// ============================================================================
// Module      : mem_wb_stage_pkg
// Description : Shared widths, data-memory geometry and address helpers for
//               the memory/write-back end of the pipeline.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mem_wb_stage_pkg;

   localparam int ADDRESS_LEN    = 32;
   localparam int DATA_MEM_BASE  = 1024;
   localparam int DATA_MEM_WORDS = 64;
   localparam int REG_IDX_LEN    = 4;

   // Byte offset from the memory base. An address below the base wraps to a
   // huge value, so a single unsigned compare covers both range limits.
   function automatic logic [ADDRESS_LEN-1:0] mem_offset(
      input logic [ADDRESS_LEN-1:0] addr,
      input int                     base
   );
      return addr - ADDRESS_LEN'(base);
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wb_stage_if.sv
// ============================================================================
// Module      : mem_wb_stage_if
// Description : EXE-to-MEM inputs and the write-back port produced for ID.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface mem_wb_stage_if;
   import mem_wb_stage_pkg::*;

   logic                   freeze;
   logic                   WB_EN;
   logic                   MEM_R_EN;
   logic                   MEM_W_EN;
   logic [ADDRESS_LEN-1:0] ALU_Res;
   logic [ADDRESS_LEN-1:0] Val_Rm;
   logic [REG_IDX_LEN-1:0] Dest;

   logic                   WB_WB_EN;
   logic [REG_IDX_LEN-1:0] WB_Dest;
   logic [ADDRESS_LEN-1:0] WB_Value;
   logic                   mem_err;

   // The stage side: consumes EXE results, produces the write-back port.
   modport master (
      input  freeze, WB_EN, MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm, Dest,
      output WB_WB_EN, WB_Dest, WB_Value, mem_err
   );

   modport slave (
      output freeze, WB_EN, MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm, Dest,
      input  WB_WB_EN, WB_Dest, WB_Value, mem_err
   );

endinterface

`default_nettype wire

// File: rtl/mem_wb_stage_data_memory.sv
// ============================================================================
// Module      : data_memory
// Description : Word-addressed data memory, synchronous write, combinational
//               read, with range check. Contents are never reset.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module data_memory
   import mem_wb_stage_pkg::*;
#(
   parameter int MEM_WORDS = DATA_MEM_WORDS,
   parameter int MEM_BASE  = DATA_MEM_BASE
) (
   input  wire logic                   clk,
   input  wire logic                   w_en,
   input  wire logic [ADDRESS_LEN-1:0] addr,
   input  wire logic [ADDRESS_LEN-1:0] w_data,
   output logic      [ADDRESS_LEN-1:0] r_data,
   output logic                        oor
);

   localparam int c_idx_w = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

   logic [ADDRESS_LEN-1:0] offset;
   logic [c_idx_w-1:0]     idx;
   logic [ADDRESS_LEN-1:0] mem_q [MEM_WORDS];

   always_comb begin
      offset = mem_offset(addr, MEM_BASE);
      oor    = (offset >= ADDRESS_LEN'(4 * MEM_WORDS));
      idx    = offset[c_idx_w+1:2];
      r_data = oor ? '0 : mem_q[idx];
   end

   always_ff @(posedge clk) begin
      if (w_en && !oor) begin
         mem_q[idx] <= w_data;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mem_wb_stage.sv
// ============================================================================
// Module      : mem_wb_stage
// Description : Load/store against private data memory, MEM/WB pipeline
//               register, sticky range-error flag and write-back mux.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int MEM_WORDS = DATA_MEM_WORDS,
   parameter int MEM_BASE  = DATA_MEM_BASE
) (
   input  wire logic      clk,
   input  wire logic      rst,
   mem_wb_stage_if.master bus
);

   logic                   mem_w_en;
   logic [ADDRESS_LEN-1:0] rd_data;
   logic                   oor;

   logic                   wb_en_d,   wb_en_q;
   logic                   mem_r_d,   mem_r_q;
   logic [ADDRESS_LEN-1:0] alu_d,     alu_q;
   logic [ADDRESS_LEN-1:0] rd_d,      rd_q;
   logic [REG_IDX_LEN-1:0] dest_d,    dest_q;
   logic                   mem_err_d, mem_err_q;

   // A store landing in the reset cycle must not disturb the unreset memory.
   assign mem_w_en = bus.MEM_W_EN && !bus.freeze && rst;

   data_memory #(
      .MEM_WORDS (MEM_WORDS),
      .MEM_BASE  (MEM_BASE)
   ) u_data_memory (
      .clk    (clk),
      .w_en   (mem_w_en),
      .addr   (bus.ALU_Res),
      .w_data (bus.Val_Rm),
      .r_data (rd_data),
      .oor    (oor)
   );

   always_comb begin
      wb_en_d   = wb_en_q;
      mem_r_d   = mem_r_q;
      alu_d     = alu_q;
      rd_d      = rd_q;
      dest_d    = dest_q;
      mem_err_d = mem_err_q;
      if (!bus.freeze) begin
         wb_en_d   = bus.WB_EN;
         mem_r_d   = bus.MEM_R_EN;
         alu_d     = bus.ALU_Res;
         rd_d      = bus.MEM_R_EN ? rd_data : '0;
         dest_d    = bus.Dest;
         mem_err_d = mem_err_q || ((bus.MEM_R_EN || bus.MEM_W_EN) && oor);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_en_q   <= 1'b0;
         mem_r_q   <= 1'b0;
         alu_q     <= '0;
         rd_q      <= '0;
         dest_q    <= '0;
         mem_err_q <= 1'b0;
      end else begin
         wb_en_q   <= wb_en_d;
         mem_r_q   <= mem_r_d;
         alu_q     <= alu_d;
         rd_q      <= rd_d;
         dest_q    <= dest_d;
         mem_err_q <= mem_err_d;
      end
   end

   assign bus.WB_WB_EN = wb_en_q;
   assign bus.WB_Dest  = dest_q;
   assign bus.WB_Value = mem_r_q ? rd_q : alu_q;
   assign bus.mem_err  = mem_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
// ============================================================================
// Module      : tb_mem_wb_stage
// Description : Directed self-checking bench for mem_wb_stage.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_mem_wb_stage;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;

   mem_wb_stage_if bus ();

   mem_wb_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic wb, input logic rd, input logic wr,
                        input logic [31:0] alu, input logic [31:0] val,
                        input logic [3:0] dst, input logic frz);
      bus.WB_EN    = wb;
      bus.MEM_R_EN = rd;
      bus.MEM_W_EN = wr;
      bus.ALU_Res  = alu;
      bus.Val_Rm   = val;
      bus.Dest     = dst;
      bus.freeze   = frz;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
               $urandom, $urandom, 4'($urandom), $urandom_range(0, 1));
         tick();
      end
      n_checks++;
      if ({bus.WB_WB_EN, bus.WB_Dest, bus.WB_Value, bus.mem_err} !== 38'd0)
         $display("FAIL reset_outputs: got en=%b dst=%h val=%h err=%b, expected all 0",
                  bus.WB_WB_EN, bus.WB_Dest, bus.WB_Value, bus.mem_err);
      else n_pass++;
      drive(1, 0, 0, 32'd5, 32'd0, 4'd3, 0);
      rst = 1'b1;
      tick();
      n_checks++;
      if ({bus.WB_WB_EN, bus.WB_Dest, bus.WB_Value} !== {1'b1, 4'd3, 32'd5})
         $display("FAIL reset_release: got en=%b dst=%h val=%h, expected en=1 dst=3 val=5",
                  bus.WB_WB_EN, bus.WB_Dest, bus.WB_Value);
      else n_pass++;
   endtask

   task automatic test_store_load();
      drive(0, 0, 1, 32'd1028, 32'hDEADBEEF, 4'd0, 0);
      tick();
      n_checks++;
      if (bus.WB_WB_EN !== 1'b0)
         $display("FAIL store_wb_en: got %b expected 0", bus.WB_WB_EN);
      else n_pass++;
      drive(1, 1, 0, 32'd1028, 32'd0, 4'd7, 0);
      tick();
      n_checks++;
      if ({bus.WB_WB_EN, bus.WB_Dest, bus.WB_Value, bus.mem_err} !== {1'b1, 4'd7, 32'hDEADBEEF, 1'b0})
         $display("FAIL store_load: got en=%b dst=%h val=%h err=%b, expected en=1 dst=7 val=deadbeef err=0",
                  bus.WB_WB_EN, bus.WB_Dest, bus.WB_Value, bus.mem_err);
      else n_pass++;
   endtask

   task automatic test_alignment();
      drive(0, 0, 1, 32'd1025, 32'h0BADF00D, 4'd0, 0);
      tick();
      drive(1, 1, 0, 32'd1027, 32'd0, 4'd1, 0);
      tick();
      n_checks++;
      if (bus.WB_Value !== 32'h0BADF00D)
         $display("FAIL align_1027: got %h expected 0badf00d", bus.WB_Value);
      else n_pass++;
      drive(1, 1, 0, 32'd1024, 32'd0, 4'd1, 0);
      tick();
      n_checks++;
      if (bus.WB_Value !== 32'h0BADF00D)
         $display("FAIL align_1024: got %h expected 0badf00d", bus.WB_Value);
      else n_pass++;
   endtask

   task automatic test_freeze();
      drive(0, 0, 1, 32'd1032, 32'hA5A5A5A5, 4'd0, 0);
      tick();
      drive(1, 0, 0, 32'h99, 32'd0, 4'd9, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 1, 32'd1032, 32'h00000BAD, 4'd2, 1);
         tick();
         n_checks++;
         if ({bus.WB_WB_EN, bus.WB_Dest, bus.WB_Value} !== {1'b1, 4'd9, 32'h99})
            $display("FAIL freeze_hold[%0d]: got en=%b dst=%h val=%h, expected en=1 dst=9 val=99",
                     i, bus.WB_WB_EN, bus.WB_Dest, bus.WB_Value);
         else n_pass++;
      end
      drive(1, 1, 0, 32'd4000, 32'd0, 4'd2, 1);
      tick();
      n_checks++;
      if (bus.mem_err !== 1'b0)
         $display("FAIL freeze_err: got %b expected 0", bus.mem_err);
      else n_pass++;
      drive(1, 1, 0, 32'd1032, 32'd0, 4'd4, 0);
      tick();
      n_checks++;
      if ({bus.WB_Dest, bus.WB_Value} !== {4'd4, 32'hA5A5A5A5})
         $display("FAIL freeze_no_store: got dst=%h val=%h expected dst=4 val=a5a5a5a5",
                  bus.WB_Dest, bus.WB_Value);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      drive(0, 0, 1, 32'd1044, 32'h1234, 4'd0, 0);
      tick();
      drive(1, 1, 1, 32'd1044, 32'h5678, 4'd5, 0);
      tick();
      n_checks++;
      if (bus.WB_Value !== 32'h1234)
         $display("FAIL rw_pre_store: got %h expected 00001234", bus.WB_Value);
      else n_pass++;
      drive(1, 1, 0, 32'd1044, 32'd0, 4'd6, 0);
      tick();
      n_checks++;
      if (bus.WB_Value !== 32'h5678)
         $display("FAIL rw_post_store: got %h expected 00005678", bus.WB_Value);
      else n_pass++;
   endtask

   task automatic test_boundaries();
      drive(0, 0, 1, 32'd1024, 32'h11111111, 4'd0, 0);
      tick();
      drive(0, 0, 1, 32'd1276, 32'h22222222, 4'd0, 0);
      tick();
      drive(1, 1, 0, 32'd1024, 32'd0, 4'd8, 0);
      tick();
      n_checks++;
      if ({bus.WB_Value, bus.mem_err} !== {32'h11111111, 1'b0})
         $display("FAIL bound_1024: got val=%h err=%b expected val=11111111 err=0",
                  bus.WB_Value, bus.mem_err);
      else n_pass++;
      drive(1, 1, 0, 32'd1276, 32'd0, 4'd8, 0);
      tick();
      n_checks++;
      if ({bus.WB_Value, bus.mem_err} !== {32'h22222222, 1'b0})
         $display("FAIL bound_1276: got val=%h err=%b expected val=22222222 err=0",
                  bus.WB_Value, bus.mem_err);
      else n_pass++;
      drive(1, 1, 0, 32'd1280, 32'd0, 4'd8, 0);
      tick();
      n_checks++;
      if ({bus.WB_Value, bus.mem_err} !== {32'd0, 1'b1})
         $display("FAIL bound_1280: got val=%h err=%b expected val=0 err=1",
                  bus.WB_Value, bus.mem_err);
      else n_pass++;
      drive(1, 1, 0, 32'd1020, 32'd0, 4'd8, 0);
      tick();
      n_checks++;
      if ({bus.WB_Value, bus.mem_err} !== {32'd0, 1'b1})
         $display("FAIL bound_1020: got val=%h err=%b expected val=0 err=1",
                  bus.WB_Value, bus.mem_err);
      else n_pass++;
      drive(1, 0, 0, 32'd7, 32'd0, 4'd1, 0);
      tick();
      n_checks++;
      if ({bus.WB_Value, bus.mem_err} !== {32'd7, 1'b1})
         $display("FAIL err_sticky: got val=%h err=%b expected val=7 err=1",
                  bus.WB_Value, bus.mem_err);
      else n_pass++;
   endtask

   task automatic test_mid_reset();
      drive(0, 0, 1, 32'd1040, 32'h55, 4'd0, 0);
      tick();
      drive(0, 0, 1, 32'd1040, 32'h77, 4'd0, 0);
      rst = 1'b0;
      tick();
      n_checks++;
      if ({bus.WB_WB_EN, bus.WB_Value, bus.mem_err} !== 34'd0)
         $display("FAIL mid_reset_outputs: got en=%b val=%h err=%b expected all 0",
                  bus.WB_WB_EN, bus.WB_Value, bus.mem_err);
      else n_pass++;
      rst = 1'b1;
      drive(1, 1, 0, 32'd1040, 32'd0, 4'd2, 0);
      tick();
      n_checks++;
      if ({bus.WB_Dest, bus.WB_Value, bus.mem_err} !== {4'd2, 32'h55, 1'b0})
         $display("FAIL mid_reset_load: got dst=%h val=%h err=%b expected dst=2 val=55 err=0",
                  bus.WB_Dest, bus.WB_Value, bus.mem_err);
      else n_pass++;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      test_reset();
      test_store_load();
      test_alignment();
      test_freeze();
      test_back_to_back();
      test_boundaries();
      test_mid_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access and write-back end of the pipeline. Consumes the EXE-stage register outputs, performs word loads and stores against a private 64-word data memory, registers the result in the MEM/WB pipeline register, and drives the write-back port (`WB_WB_EN`, `WB_Dest`, `WB_Value`) that the ID stage uses to write the register file. It is the producer end of the write-back interface.

## Interface
Parameters:
- `MEM_WORDS`, 64: data-memory depth in 32-bit words; must be a power of two.
- `MEM_BASE`, 1024: byte address of word 0.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `freeze`, input, 1: when 1, the MEM/WB register holds its value and no store is performed.
- `WB_EN`, input, 1: the instruction writes a register.
- `MEM_R_EN`, input, 1: load.
- `MEM_W_EN`, input, 1: store.
- `ALU_Res`, input, 32: effective byte address for loads and stores; result value otherwise.
- `Val_Rm`, input, 32: store data.
- `Dest`, input, 4: destination register number.
- `WB_WB_EN`, output, 1: register-file write enable to ID.
- `WB_Dest`, output, 4: register-file write index.
- `WB_Value`, output, 32: register-file write data.
- `mem_err`, output, 1: sticky flag, set by any out-of-range load or store.

## Operation
- Word index is `idx = (ALU_Res - MEM_BASE) >> 2`, computed as 32-bit unsigned. The low two address bits are ignored.
- An address is in range iff `MEM_BASE <= ALU_Res < MEM_BASE + 4*MEM_WORDS`.
- **Store** (`MEM_W_EN=1`, `freeze=0`, in range): `mem[idx] <= Val_Rm` at the rising edge. An out-of-range store is dropped and sets `mem_err`.
- **Load** (`MEM_R_EN=1`, in range): the memory read is combinational, `rd = mem[idx]`. An out-of-range load gives `rd = 0` and sets `mem_err`.
- MEM/WB register fields: `wb_en_q`, `mem_r_q`, `alu_q`, `rd_q`, `dest_q`. They load every edge unless `freeze=1`.
- Write-back mux: `WB_Value = mem_r_q ? rd_q : alu_q`, `WB_WB_EN = wb_en_q`, `WB_Dest = dest_q`.
- `MEM_R_EN` and `MEM_W_EN` both set is not produced by the decoder. If it occurs:
  - the store happens;
  - the load returns the pre-store word.
- `mem_err` is cleared only by reset.
- Under `freeze=1`, `mem_err` is also not updated.

## Timing
- Latency: an instruction presented in cycle N appears on the WB outputs in cycle N+1.
- The WB outputs are purely registered plus the mux; there is no combinational path from inputs to `WB_*`.
- Store in cycle N followed by a load of the same address in cycle N+1: the load returns the stored data.
- Reset values (asserted asynchronously, released synchronously to the design):
  - `WB_WB_EN=0`, `WB_Dest=0`, `WB_Value=0`, `mem_err=0`;
  - all MEM/WB fields are 0.
- Memory contents are not reset. A reset mid-operation preserves all stored words, and any store in the reset cycle is suppressed.
- `freeze` asserted: the WB outputs repeat the previous cycle's values. The ID stage therefore sees a repeated write of the same value, which is idempotent.

## Structure
- Add to `configs.v`:
  - `` `DATA_MEM_BASE `` (1024);
  - `` `DATA_MEM_WORDS `` (64);
  - reuse `` `ADDRESS_LEN `` (32) for all 32-bit widths.
- One sub-module, `data_memory`:
  - synchronous write, combinational read;
  - range check and index computation inside;
  - ports `clk`, `w_en`, `addr`, `w_data`, `r_data`, `oor`.
- `mem_wb_stage` holds the MEM/WB register, the `mem_err` flag and the write-back mux.

## Test plan
- **Reset:** hold `rst=0` with random inputs. Required: all outputs 0. Release reset with `WB_EN=1`, `ALU_Res=5`, `Dest=3`. Required next cycle: `WB_WB_EN=1`, `WB_Dest=3`, `WB_Value=5`.
- **Store then load:** store `Val_Rm=0xDEADBEEF` at 1028, then load from 1028 with `Dest=7`. Required on the load's WB cycle: `WB_Value=0xDEADBEEF`, `WB_Dest=7`, `mem_err=0`.
- **Boundaries:** store/load at 1024 and at 1276 succeed. Load at 1280 and at 1020 returns `WB_Value=0`, and `mem_err` goes 1 and stays 1.
- **Freeze:** assert `freeze` for 3 cycles while presenting a store to 1032. Required:
  - the WB outputs stay constant;
  - a later load from 1032 returns the prior contents.
- **Mid-operation reset:** store 0x55 at 1040, pulse `rst`, then load 1040. Required: `WB_Value=0x55`, `mem_err=0`.
- **Address alignment:** store at 1025 and load from 1027. Required: both target word 0, and the load returns the stored value.
